// File: rtl/activation_interp.sv
// activation_interp
//   Pipelined consumer of the activation-function LUT. A signed fixed-point
//   pre-activation x is split into a LUT address (top ADDR_WIDTH bits) and an
//   interpolation fraction (low FRAC_WIDTH bits). The result is
//   y = sat(base + floor((next - base) * frac / 2**FRAC_WIDTH)).
//   Fixed latency is 3 cycles. A single enable moves all three stages forward
//   together, so a stalled output freezes the whole pipe.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   input handshake, in_data = signed x
//   lut_address      LUT address, taken from the stage A register
//   lut_base/next    signed LUT entries for lut_address (combinational LUT)
//   out_valid/ready  output handshake, out_data = signed interpolated y
//   busy             at least one stage holds a valid item
module activation_interp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FRAC_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [ADDR_WIDTH-1:0] lut_address,
  input  logic [DATA_WIDTH-1:0] lut_base,
  input  logic [DATA_WIDTH-1:0] lut_next,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int DW = DATA_WIDTH + 1;               // delta width
  localparam int PW = DATA_WIDTH + FRAC_WIDTH + 2;  // product width

  logic                  adv;
  logic                  accept;

  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [FRAC_WIDTH-1:0] a_frac;

  logic                  b_valid;
  logic [DATA_WIDTH-1:0] b_base;
  logic [DATA_WIDTH-1:0] b_next;
  logic [FRAC_WIDTH-1:0] b_frac;

  logic signed [DW-1:0]         delta;
  logic signed [PW-1:0]         delta_x;
  logic signed [PW-1:0]         frac_x;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         shifted;
  logic signed [PW-1:0]         sum;
  logic [PW-DATA_WIDTH:0]       sum_top;
  logic [DATA_WIDTH-1:0]        y_sat;

  assign adv         = !(out_valid && !out_ready);
  assign in_ready    = adv && !rst;
  assign accept      = in_valid && in_ready;
  assign lut_address = a_addr;
  assign busy        = a_valid | b_valid | out_valid;

  always_comb begin
    delta   = {b_next[DATA_WIDTH-1], b_next} - {b_base[DATA_WIDTH-1], b_base};
    delta_x = {{(PW-DW){delta[DW-1]}}, delta};
    // Fraction is an unsigned magnitude: zero-extend so it multiplies as {0,frac}.
    frac_x  = {{(PW-FRAC_WIDTH){1'b0}}, b_frac};
    prod    = delta_x * frac_x;
    // Arithmetic shift gives floor rounding for negative slopes.
    shifted = prod >>> FRAC_WIDTH;
    sum     = {{(PW-DATA_WIDTH){b_base[DATA_WIDTH-1]}}, b_base} + shifted;
    // In range only when every bit above the result's sign bit matches it.
    sum_top = sum[PW-1:DATA_WIDTH-1];
    if ((&sum_top) || !(|sum_top)) begin
      y_sat = sum[DATA_WIDTH-1:0];
    end else if (sum[PW-1]) begin
      y_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_addr    <= '0;
      a_frac    <= '0;
      b_valid   <= 1'b0;
      b_base    <= '0;
      b_next    <= '0;
      b_frac    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      a_valid <= accept;
      if (accept) begin
        a_addr <= in_data[DATA_WIDTH-1 -: ADDR_WIDTH];
        a_frac <= in_data[FRAC_WIDTH-1:0];
      end
      // LUT outputs belong to a_addr, so they are captured on the same edge
      // that stage A moves into stage B.
      b_valid   <= a_valid;
      b_base    <= lut_base;
      b_next    <= lut_next;
      b_frac    <= a_frac;
      out_valid <= b_valid;
      out_data  <= y_sat;
    end
  end

endmodule

// File: tb/tb_activation_interp.sv
module tb_activation_interp;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] lut_address;
  logic [7:0] lut_base;
  logic [7:0] lut_next;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic       force_lut = 1'b0;
  logic [7:0] force_base = 8'h00;
  logic [7:0] force_next = 8'h00;

  typedef struct {
    logic       acc;
    logic       fire;
    logic       ov;
    logic       ir;
    logic       bsy;
    logic [7:0] y;
    logic [3:0] addr;
  } obs_t;

  always #5 clk = ~clk;

  activation_interp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FRAC_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lut_address(lut_address), .lut_base(lut_base), .lut_next(lut_next),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  // LUT model: lut[a] = 16*a for 0..7, 0 for 8..15; next clamps at 7, wraps 15->0.
  function automatic int lut_val(input int a);
    return (a < 8) ? 16 * a : 0;
  endfunction

  function automatic int next_val(input int a);
    if (a == 7) return lut_val(7);
    if (a == 15) return lut_val(0);
    return lut_val(a + 1);
  endfunction

  always_comb begin
    if (force_lut) begin
      lut_base = force_base;
      lut_next = force_next;
    end else begin
      lut_base = 8'(lut_val(int'(lut_address)));
      lut_next = 8'(next_val(int'(lut_address)));
    end
  end

  // Reference: y = sat(base + floor((next-base)*frac/16)) in plain integers.
  function automatic logic [7:0] ref_y(input logic [7:0] x);
    int a, frac, base, nxt, p, q, s;
    a    = int'(x[7:4]);
    frac = int'(x[3:0]);
    base = lut_val(a);
    nxt  = next_val(a);
    p    = (nxt - base) * frac;
    q    = p / 16;
    if (p < 0 && (p % 16) != 0) q = q - 1;
    s = base + q;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  // Drives one cycle's inputs, records what the DUT shows in that cycle, then
  // moves to 1 time unit after the next rising edge.
  task automatic cycle(input logic iv, input logic [7:0] x, input logic ordy, output obs_t o);
    in_valid  = iv;
    in_data   = x;
    out_ready = ordy;
    #1;
    o.acc  = in_valid && in_ready;
    o.fire = out_valid && out_ready;
    o.ov   = out_valid;
    o.ir   = in_ready;
    o.bsy  = busy;
    o.y    = out_data;
    o.addr = lut_address;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    cycle(1'b1, 8'h25, 1'b1, o);
    cycle(1'b1, 8'h25, 1'b0, o);
    checks++;
    if (o.ir !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", o.ir); end
    checks++;
    if (o.ov !== 1'b0 || o.bsy !== 1'b0) begin
      errors++; $display("FAIL reset_valid_busy got ov=%b busy=%b want 0/0", o.ov, o.bsy);
    end
    checks++;
    if (o.y !== 8'h00 || o.addr !== 4'h0) begin
      errors++; $display("FAIL reset_data got y=%h addr=%h want 00/0", o.y, o.addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    obs_t o;
    cycle(1'b1, 8'h25, 1'b1, o);
    checks++;
    if (o.ir !== 1'b1 || o.acc !== 1'b1) begin
      errors++; $display("FAIL single_accept got ir=%b acc=%b want 1/1", o.ir, o.acc);
    end
    for (int c = 1; c <= 3; c++) begin
      cycle(1'b0, 8'h00, 1'b1, o);
      checks++;
      if (o.bsy !== 1'b1) begin errors++; $display("FAIL single_busy cycle=%0d got=%b want=1", c, o.bsy); end
      if (c == 1) begin
        checks++;
        if (o.addr !== 4'h2) begin errors++; $display("FAIL single_addr got=%h want=2", o.addr); end
      end
      if (c < 3) begin
        checks++;
        if (o.ov !== 1'b0) begin errors++; $display("FAIL single_early cycle=%0d got ov=%b want=0", c, o.ov); end
      end else begin
        checks++;
        if (o.ov !== 1'b1 || o.y !== 8'd37) begin
          errors++; $display("FAIL single_result got ov=%b y=%0d want ov=1 y=37", o.ov, $signed(o.y));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [7:0] stim [5];
    logic [7:0] expv [5];
    stim = '{8'h00, 8'h10, 8'h7F, 8'hF3, 8'h8A};
    expv = '{8'd0, 8'd16, 8'd112, 8'd0, 8'd0};
    for (int c = 0; c < 8; c++) begin
      cycle(c < 5, (c < 5) ? stim[c] : 8'h00, 1'b1, o);
      if (c < 5) begin
        checks++;
        if (o.acc !== 1'b1) begin errors++; $display("FAIL b2b_accept cycle=%0d got=%b want=1", c, o.acc); end
      end
      if (c >= 3) begin
        checks++;
        if (o.ov !== 1'b1 || o.y !== expv[c-3]) begin
          errors++;
          $display("FAIL b2b_out cycle=%0d got ov=%b y=%0d want ov=1 y=%0d", c, o.ov, $signed(o.y), $signed(expv[c-3]));
        end
      end
    end
  endtask

  task automatic test_stall();
    obs_t o;
    logic [7:0] stim [5];
    logic [7:0] expv [5];
    logic [7:0] got [$];
    int idx = 0;
    stim = '{8'h00, 8'h10, 8'h7F, 8'hF3, 8'h8A};
    expv = '{8'd0, 8'd16, 8'd112, 8'd0, 8'd0};
    for (int c = 0; c < 30 && got.size() < 5; c++) begin
      cycle(idx < 5, (idx < 5) ? stim[idx] : 8'h00, !(c >= 3 && c <= 6), o);
      if (o.acc) idx++;
      if (o.fire) got.push_back(o.y);
      if (c >= 3 && c <= 6) begin
        checks++;
        if (o.ir !== 1'b0 || o.ov !== 1'b1 || o.y !== 8'h00) begin
          errors++;
          $display("FAIL stall_hold cycle=%0d got ir=%b ov=%b y=%0d want ir=0 ov=1 y=0", c, o.ir, o.ov, $signed(o.y));
        end
      end
    end
    checks++;
    if (got.size() != 5) begin
      errors++; $display("FAIL stall_count got=%0d want=5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== expv[i]) begin
          errors++; $display("FAIL stall_order item=%0d got=%0d want=%0d", i, $signed(got[i]), $signed(expv[i]));
        end
      end
    end
  endtask

  task automatic test_extremes();
    obs_t o;
    logic [7:0] bases [2];
    logic [7:0] nexts [2];
    logic [7:0] expv [2];
    bases = '{8'sd127, -8'sd128};
    nexts = '{-8'sd128, 8'sd127};
    expv  = '{-8'sd113, 8'sd111};
    for (int k = 0; k < 2; k++) begin
      force_lut  = 1'b1;
      force_base = bases[k];
      force_next = nexts[k];
      cycle(1'b1, 8'h0F, 1'b1, o);
      cycle(1'b0, 8'h00, 1'b1, o);
      cycle(1'b0, 8'h00, 1'b1, o);
      cycle(1'b0, 8'h00, 1'b1, o);
      checks++;
      if (o.ov !== 1'b1 || o.y !== expv[k]) begin
        errors++; $display("FAIL extreme case=%0d got ov=%b y=%0d want ov=1 y=%0d", k, o.ov, $signed(o.y), $signed(expv[k]));
      end
    end
    force_lut = 1'b0;
  endtask

  task automatic test_midflight_reset();
    obs_t o;
    cycle(1'b1, 8'h25, 1'b1, o);
    cycle(1'b1, 8'h10, 1'b1, o);
    rst = 1'b1;
    cycle(1'b1, 8'h7F, 1'b1, o);
    checks++;
    if (o.ir !== 1'b0 || o.acc !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready got ir=%b acc=%b want 0/0", o.ir, o.acc);
    end
    for (int c = 3; c <= 4; c++) begin
      cycle(1'b1, 8'h7F, 1'b0, o);
      checks++;
      if (o.ov !== 1'b0 || o.bsy !== 1'b0 || o.y !== 8'h00 || o.ir !== 1'b0) begin
        errors++; $display("FAIL rst_clear cycle=%0d got ov=%b busy=%b y=%h ir=%b want 0/0/00/0", c, o.ov, o.bsy, o.y, o.ir);
      end
    end
    rst = 1'b0;
    cycle(1'b1, 8'h3C, 1'b1, o);
    checks++;
    if (o.acc !== 1'b1) begin errors++; $display("FAIL rst_release_accept got=%b want=1", o.acc); end
    for (int c = 1; c <= 3; c++) begin
      cycle(1'b0, 8'h00, 1'b1, o);
      if (c < 3) begin
        checks++;
        if (o.ov !== 1'b0) begin errors++; $display("FAIL rst_stale_out cycle=%0d got ov=%b want=0", c, o.ov); end
      end else begin
        checks++;
        if (o.ov !== 1'b1 || o.y !== 8'd60) begin
          errors++; $display("FAIL rst_new_item got ov=%b y=%0d want ov=1 y=60", o.ov, $signed(o.y));
        end
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [7:0] q [$];
    logic [7:0] x;
    logic [7:0] prev_y = 8'h00;
    logic iv, ordy;
    logic prev_stall = 1'b0;
    int sent = 0;
    int recv = 0;
    for (int c = 0; c < 6000 && (sent < 1000 || q.size() > 0); c++) begin
      iv   = (sent < 1000) && ($urandom_range(3) != 0);
      x    = 8'($urandom);
      ordy = 1'($urandom_range(1));
      cycle(iv, x, ordy, o);
      if (prev_stall) begin
        checks++;
        if (o.ov !== 1'b1 || o.y !== prev_y) begin
          errors++; $display("FAIL rand_stall_stable cycle=%0d got ov=%b y=%h want ov=1 y=%h", c, o.ov, o.y, prev_y);
        end
      end
      checks++;
      if (o.ir !== !(o.ov && !ordy)) begin
        errors++; $display("FAIL rand_in_ready cycle=%0d got=%b want=%b", c, o.ir, !(o.ov && !ordy));
      end
      if (o.acc) begin
        q.push_back(ref_y(x));
        sent++;
      end
      if (o.fire) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious cycle=%0d got y=%h want no output", c, o.y);
        end else begin
          if (o.y !== q[0]) begin
            errors++; $display("FAIL rand_data item=%0d got=%0d want=%0d", recv, $signed(o.y), $signed(q[0]));
          end
          void'(q.pop_front());
          recv++;
        end
      end
      prev_stall = o.ov && !ordy;
      prev_y     = o.y;
    end
    checks++;
    if (sent != 1000 || recv != 1000 || q.size() != 0) begin
      errors++; $display("FAIL rand_complete got sent=%0d recv=%0d pending=%0d want 1000/1000/0", sent, recv, q.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_extremes();
    test_midflight_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
